div_seq_ctrl: RTL and testbench

- Sequencing controller between the CPU execute stage and the 32-bit iterative unsigned divider core.
- Accepts DIV/DIVU requests and converts signed operands to magnitudes.
- Launches the core, tracks its busy/done, and applies the sign correction.
- Writes HI (remainder) and LO (quotient), stalls the pipeline while a divide is in flight, and supports cancellation on pipeline flush.

---
 rtl/div_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// Sequencing controller between the execute stage and a falling-edge iterative
// unsigned divider core. The optional divide-by-zero bypass is enabled by DIV_ZERO_BYPASS_EN.
module div_seq_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_signed,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             stall,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_busy,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             hilo_we,
    output logic             timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_RUN    = 3'd3,
        S_FIX    = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    state_t           state_q;
    logic             negq_q;
    logic             negr_q;
    logic [CW-1:0]    tcnt_q;
    logic             div_start_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             hilo_we_q;
    logic             timeout_err_q;

    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH-1:0] dvs_d;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH-1:0] hi_d;
    logic             stall_s;

    // Two's complement negation modulo 2^WIDTH (so the most negative value maps to itself).
    function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand magnitudes for the core and sign-corrected results from it.
    always_comb begin
        dvd_d = (req_signed && rs_val[WIDTH-1]) ? neg2c(rs_val) : rs_val;
        dvs_d = (req_signed && rt_val[WIDTH-1]) ? neg2c(rt_val) : rt_val;
        lo_d  = negq_q ? neg2c(div_q) : div_q;
        hi_d  = negr_q ? neg2c(div_r) : div_r;
    end

    // Pipeline hold: a flush releases the stage at once; drain holds only a waiting request.
    always_comb begin
        stall_s = 1'b0;
        case (state_q)
            S_IDLE:   stall_s = req_valid && !flush;
            S_LAUNCH: stall_s = !flush;
            S_WAIT:   stall_s = !flush;
            S_RUN:    stall_s = !flush;
            S_FIX:    stall_s = 1'b0;
            S_DRAIN:  stall_s = req_valid;
            default:  stall_s = 1'b0;
        endcase
    end

    // Controller state machine with registered core handshake and HI/LO outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            negq_q        <= 1'b0;
            negr_q        <= 1'b0;
            tcnt_q        <= {CW{1'b0}};
            div_start_q   <= 1'b0;
            dvd_q         <= {WIDTH{1'b0}};
            dvs_q         <= {WIDTH{1'b0}};
            hi_q          <= {WIDTH{1'b0}};
            lo_q          <= {WIDTH{1'b0}};
            hilo_we_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            div_start_q <= 1'b0;
            hilo_we_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        negq_q <= req_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        negr_q <= req_signed & rs_val[WIDTH-1];
                        dvd_q  <= dvd_d;
                        dvs_q  <= dvs_d;
`ifdef DIV_ZERO_BYPASS_EN
                        if (rt_val == {WIDTH{1'b0}}) begin
                            lo_q      <= {WIDTH{1'b1}};
                            hi_q      <= rs_val;
                            hilo_we_q <= 1'b1;
                            state_q   <= S_FIX;
                        end else begin
                            div_start_q <= 1'b1;
                            state_q     <= S_LAUNCH;
                        end
`else
                        div_start_q <= 1'b1;
                        state_q     <= S_LAUNCH;
`endif
                    end
                end
                S_LAUNCH: begin
                    tcnt_q  <= {CW{1'b0}};
                    state_q <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (flush) begin
                        state_q <= S_DRAIN;
                    end else if (tcnt_q >= CW'(TIMEOUT)) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + CW'(1);
                        if (div_busy) begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state_q <= S_DRAIN;
                    end else if (!div_busy) begin
                        lo_q      <= lo_d;
                        hi_q      <= hi_d;
                        hilo_we_q <= 1'b1;
                        state_q   <= S_FIX;
                    end else if (tcnt_q >= CW'(TIMEOUT)) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + CW'(1);
                    end
                end
                // HI/LO were written on entry; a flush here has nothing left to cancel.
                S_FIX: begin
                    state_q <= S_IDLE;
                end
                S_DRAIN: begin
                    if (!div_busy) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stall        = stall_s;
    assign div_start    = div_start_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign hi           = hi_q;
    assign lo           = lo_q;
    assign hilo_we      = hilo_we_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a behavioural falling-edge divider core;
// honours DIV_ZERO_BYPASS_EN for the divide-by-zero case.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_signed, flush;
    logic [31:0] rs_val, rt_val;
    logic        stall, div_start, div_busy, hilo_we, timeout_err;
    logic [31:0] div_dividend, div_divisor, div_q, div_r, hi, lo;

    int n_cmp = 0;
    int n_err = 0;
    int n_we = 0;
    int n_start = 0;
    int bad_start = 0;
    int exp_we = 0;
    logic        hang;
    logic [5:0]  core_cnt;
    logic [31:0] core_a, core_b;

    div_seq_ctrl #(.WIDTH(32), .TIMEOUT(40)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_signed(req_signed),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .stall(stall),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_busy(div_busy), .div_q(div_q), .div_r(div_r), .hi(hi), .lo(lo),
        .hilo_we(hilo_we), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Core model: samples start on the falling edge and stays busy for 34 falling edges.
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            div_busy <= 1'b0;
            core_cnt <= 6'd0;
            core_a   <= 32'd0;
            core_b   <= 32'd0;
            div_q    <= 32'd0;
            div_r    <= 32'd0;
        end else if (!div_busy) begin
            if (div_start) begin
                div_busy <= 1'b1;
                core_cnt <= 6'd34;
                core_a   <= div_dividend;
                core_b   <= div_divisor;
            end
        end else if (!hang) begin
            if (core_cnt == 6'd1) begin
                div_busy <= 1'b0;
                div_q    <= (core_b == 32'd0) ? 32'hFFFF_FFFF : core_a / core_b;
                div_r    <= (core_b == 32'd0) ? core_a : core_a % core_b;
            end else begin
                core_cnt <= core_cnt - 6'd1;
            end
        end
    end

    // Event counters for write pulses, start pulses and starts issued into a busy core.
    always @(negedge clk) begin
        if (!reset) begin
            if (hilo_we) n_we <= n_we + 1;
            if (div_start) n_start <= n_start + 1;
            if (div_start && div_busy) bad_start <= bad_start + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, need 0x%08h", tag, obs, exp);
        end
    endtask

    // Holds the request until the stage is released, then checks the retiring FIX cycle.
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input string tag, output int ncyc);
        bit done = 1'b0;
        req_signed = sg; rs_val = a; rt_val = b; req_valid = 1'b1;
        ncyc = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (stall) ncyc++;
            else done = 1'b1;
        end
        chk({tag, " released"}, 32'(done), 32'd1);
        chk({tag, " hilo_we"}, 32'(hilo_we), 32'd1);
        chk({tag, " lo"}, lo, exp_lo);
        chk({tag, " hi"}, hi, exp_hi);
        exp_we++;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int n;
        int s0;
        int cyc;
        bit seen;
        reset = 1'b1; req_valid = 1'b0; req_signed = 1'b0; flush = 1'b0; hang = 1'b0;
        rs_val = 32'd0; rt_val = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst start", 32'(div_start), 32'd0);
        chk("rst we", 32'(hilo_we), 32'd0);
        chk("rst tmo", 32'(timeout_err), 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst dvd", div_dividend, 32'd0);
        chk("rst dvs", div_divisor, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "divu 100/7", n);
        chk("divu 100/7 stall cycles", 32'(n), 32'd36);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div -7/2", n);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, "div 7/-2", n);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "div min/-1", n);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, "divu max/1", n);

        s0 = n_start;
        run_div(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, "b2b 50/5", n);
        run_div(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, "b2b 9/4", n);
        chk("b2b start pulses", 32'(n_start - s0), 32'd2);

        // Flush ten cycles after acceptance, then a new request waits in drain.
        req_signed = 1'b0; rs_val = 32'd100; rt_val = 32'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        req_signed = 1'b0; rs_val = 32'd1000; rt_val = 32'd10; req_valid = 1'b1;
        @(negedge clk);
        chk("drain stall", 32'(stall), 32'd1);
        chk("drain lo kept", lo, 32'd2);
        chk("drain hi kept", hi, 32'd1);
        run_div(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, "post-flush", n);
        chk("we count", 32'(n_we), 32'(exp_we));
        chk("start while busy", 32'(bad_start), 32'd0);

        s0 = n_start;
`ifdef DIV_ZERO_BYPASS_EN
        run_div(1'b0, 32'd123, 32'd0, 32'hFFFF_FFFF, 32'd123, "bypass 123/0", n);
        chk("bypass stall cycles", 32'(n), 32'd1);
        chk("bypass no start", 32'(n_start - s0), 32'd0);
`else
        run_div(1'b0, 32'd123, 32'd0, 32'hFFFF_FFFF, 32'd123, "core 123/0", n);
        chk("core 123/0 stall cycles", 32'(n), 32'd36);
        chk("core 123/0 start", 32'(n_start - s0), 32'd1);
`endif

        // Core stuck busy: the controller must give up and return to idle.
        hang = 1'b1;
        req_signed = 1'b0; rs_val = 32'd5; rt_val = 32'd1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 1'b0; cyc = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (timeout_err) seen = 1'b1;
            else cyc++;
        end
        chk("timeout raised", 32'(seen), 32'd1);
        chk("timeout not early", 32'(cyc >= 40 && cyc <= 44), 32'd1);
        chk("timeout idle stall", 32'(stall), 32'd0);
        chk("timeout lo kept", lo, 32'hFFFF_FFFF);
        chk("timeout hi kept", hi, 32'd123);
        repeat (3) @(negedge clk);
        chk("timeout sticky", 32'(timeout_err), 32'd1);
        chk("timeout no write", 32'(n_we), 32'(exp_we));

        #1 reset = 1'b1; hang = 1'b0;
        @(negedge clk);
        chk("reset clears tmo", 32'(timeout_err), 32'd0);
        chk("reset clears lo", lo, 32'd0);
        chk("reset clears hi", hi, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
